// File: rtl/adder_4bit.sv
// rtl/adder_4bit.sv - 4-bit ripple-carry adder with registered sum/carry; optional V via ADDER_4BIT_OVF_EN

// Half adder: sum and carry of two bits.
module adder_4bit_half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// Full adder cell built from two half adders plus an OR on the two partial carries.
module adder_4bit_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic p;
    logic g;
    logic t;

    adder_4bit_half_adder u_ha_ab (
        .a     (a),
        .b     (b),
        .sum   (p),
        .carry (g)
    );

    adder_4bit_half_adder u_ha_pc (
        .a     (p),
        .b     (cin),
        .sum   (sum),
        .carry (t)
    );

    assign cout = g | t;

endmodule

// Top: ripple chain of four full adders feeding one output register stage.
module adder_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    output logic [WIDTH-1:0] S,
    output logic             C_out
`ifdef ADDER_4BIT_OVF_EN
    ,
    output logic             V
`endif
);

    // c[i] is the carry into bit i; c[WIDTH] is the carry out of the top bit.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = C_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        adder_4bit_full_adder u_fa (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (c[i]),
            .sum  (s[i]),
            .cout (c[i+1])
        );
    end

    // Register sum and carry-out; reset wins over whatever the operands are.
    always_ff @(posedge clk) begin
        if (rst) begin
            S     <= '0;
            C_out <= 1'b0;
        end else begin
            S     <= s;
            C_out <= c[WIDTH];
        end
    end

`ifdef ADDER_4BIT_OVF_EN
    // Two's-complement overflow: carry into the sign bit differs from carry out of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            V <= 1'b0;
        end else begin
            V <= c[WIDTH] ^ c[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_adder_4bit.sv
// tb/tb_adder_4bit.sv - self-checking bench for adder_4bit (randomized + directed vs. arithmetic model)

module tb_adder_4bit;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       c_in;
    logic [3:0] s;
    logic       c_out;
`ifdef ADDER_4BIT_OVF_EN
    logic       v;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    adder_4bit dut (
        .clk   (clk),
        .rst   (rst),
        .A     (a),
        .B     (b),
        .C_in  (c_in),
        .S     (s),
        .C_out (c_out)
`ifdef ADDER_4BIT_OVF_EN
        ,
        .V     (v)
`endif
    );

    // Reference: plain integer sum of the unsigned operands.
    function automatic int ref_sum(input int x, input int y, input int ci);
        return x + y + ci;
    endfunction

    // Reference: signed overflow from the signed interpretation of the operands.
    function automatic bit ref_ovf(input int x, input int y, input int ci);
        int sx;
        int sy;
        int r;
        sx = (x > 7) ? x - 16 : x;
        sy = (y > 7) ? y - 16 : y;
        r  = sx + sy + ci;
        return (r > 7) || (r < -8);
    endfunction

    // Drive operands, then advance one edge and settle past it.
    task automatic step(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
        a    = ta;
        b    = tb;
        c_in = tc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(4'hf, 4'hf, 1'b1);
        step(4'hf, 4'hf, 1'b1);
        total++;
        if (s !== 4'h0 || c_out !== 1'b0) begin
            $display("FAIL reset: S=%b C_out=%b expected S=0000 C_out=0", s, c_out);
        end else begin
            passed++;
        end
`ifdef ADDER_4BIT_OVF_EN
        total++;
        if (v !== 1'b0) $display("FAIL reset_v: V=%b expected 0", v);
        else passed++;
`endif
        rst = 1'b0;
    endtask

    task automatic test_directed();
        // {A, B, C_in, S_expected, C_out_expected}
        logic [13:0] tbl [8];
        int          sum;
        tbl = '{
            {4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0},
            {4'b0001, 4'b0001, 1'b0, 4'b0010, 1'b0},
            {4'b0010, 4'b0011, 1'b0, 4'b0101, 1'b0},
            {4'b0101, 4'b0011, 1'b1, 4'b1001, 1'b0},
            {4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1},
            {4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1},
            {4'b1010, 4'b0110, 1'b1, 4'b0001, 1'b1},
            {4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1}
        };
        for (int i = 0; i < 8; i++) begin
            step(tbl[i][13:10], tbl[i][9:6], tbl[i][5]);
            sum = ref_sum(int'(tbl[i][13:10]), int'(tbl[i][9:6]), int'(tbl[i][5]));
            total++;
            if (s !== tbl[i][4:1] || c_out !== tbl[i][0] || {c_out, s} !== 5'(sum)) begin
                $display("FAIL directed[%0d]: %0d+%0d+%0d got S=%b C_out=%b expected S=%b C_out=%b",
                         i, tbl[i][13:10], tbl[i][9:6], tbl[i][5], s, c_out, tbl[i][4:1], tbl[i][0]);
            end else begin
                passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ta;
        logic [3:0] tb;
        logic       tc;
        int         sum;
        for (int i = 0; i < 200; i++) begin
            ta  = 4'($urandom_range(0, 15));
            tb  = 4'($urandom_range(0, 15));
            tc  = 1'($urandom_range(0, 1));
            step(ta, tb, tc);
            sum = ref_sum(int'(ta), int'(tb), int'(tc));
            total++;
            if (int'(s) !== sum % 16 || int'(c_out) !== sum / 16) begin
                $display("FAIL back_to_back[%0d]: %0d+%0d+%0d got S=%0d C_out=%0d expected S=%0d C_out=%0d",
                         i, ta, tb, tc, s, c_out, sum % 16, sum / 16);
            end else begin
                passed++;
            end
`ifdef ADDER_4BIT_OVF_EN
            total++;
            if (v !== ref_ovf(int'(ta), int'(tb), int'(tc)))
                $display("FAIL back_to_back_v[%0d]: V=%b expected %b", i, v, ref_ovf(int'(ta), int'(tb), int'(tc)));
            else passed++;
`endif
        end
    endtask

    task automatic test_reset_midstream();
        step(4'hf, 4'hf, 1'b1);
        total++;
        if (s !== 4'b1111 || c_out !== 1'b1)
            $display("FAIL midstream_pre: S=%b C_out=%b expected S=1111 C_out=1", s, c_out);
        else passed++;
        rst = 1'b1;
        step(4'hf, 4'hf, 1'b1);
        total++;
        if (s !== 4'b0000 || c_out !== 1'b0)
            $display("FAIL midstream_rst: S=%b C_out=%b expected S=0000 C_out=0", s, c_out);
        else passed++;
        rst = 1'b0;
        step(4'hf, 4'hf, 1'b1);
        total++;
        if (s !== 4'b1111 || c_out !== 1'b1)
            $display("FAIL midstream_post: S=%b C_out=%b expected S=1111 C_out=1", s, c_out);
        else passed++;
    endtask

    task automatic test_exhaustive();
        int sum;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    step(4'(ia), 4'(ib), 1'(ic));
                    sum = ref_sum(ia, ib, ic);
                    total++;
                    if (int'(s) !== sum % 16 || int'(c_out) !== sum / 16) begin
                        $display("FAIL exhaustive: %0d+%0d+%0d got S=%0d C_out=%0d expected S=%0d C_out=%0d",
                                 ia, ib, ic, s, c_out, sum % 16, sum / 16);
                    end else begin
                        passed++;
                    end
`ifdef ADDER_4BIT_OVF_EN
                    total++;
                    if (v !== ref_ovf(ia, ib, ic))
                        $display("FAIL exhaustive_v: %0d+%0d+%0d V=%b expected %b", ia, ib, ic, v, ref_ovf(ia, ib, ic));
                    else passed++;
`endif
                end
            end
        end
    endtask

`ifdef ADDER_4BIT_OVF_EN
    task automatic test_overflow();
        // {A, B, C_in, V_expected}
        logic [9:0] tbl [5];
        tbl = '{
            {4'b0111, 4'b0001, 1'b0, 1'b1},
            {4'b1000, 4'b1000, 1'b0, 1'b1},
            {4'b0101, 4'b0011, 1'b1, 1'b1},
            {4'b0001, 4'b0001, 1'b0, 1'b0},
            {4'b1111, 4'b1111, 1'b1, 1'b0}
        };
        for (int i = 0; i < 5; i++) begin
            step(tbl[i][9:6], tbl[i][5:2], tbl[i][1]);
            total++;
            if (v !== tbl[i][0])
                $display("FAIL overflow[%0d]: V=%b expected %b", i, v, tbl[i][0]);
            else passed++;
        end
    endtask
`endif

    initial begin
        rst  = 1'b1;
        a    = 4'h0;
        b    = 4'h0;
        c_in = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midstream();
        test_exhaustive();
`ifdef ADDER_4BIT_OVF_EN
        test_overflow();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
